// File: rtl/rr_onehot_sched_if.sv
// Requester-side handshake bundle for the 8-way round-robin scheduler.
// master = requester agents, slave = scheduler.
interface rr_onehot_sched_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    modport master (output en, req, input gnt, gnt_id, gnt_valid, preempt);
    modport slave  (input en, req, output gnt, gnt_id, gnt_valid, preempt);
endinterface

// File: rtl/rr_onehot_sched.sv
// Round-robin scheduler for one 8-way resource: registered one-hot grant,
// binary ID, hold-limit preemption and a forced idle cycle between grants.
module rr_onehot_sched #(
    parameter int MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_onehot_sched_if.slave  bus
);
    localparam int NUM_REQ = 8;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state;
    logic [2:0]           ptr;
    logic [7:0]           hold_cnt;
    logic [2:0]           win_id;
    logic                 win_hit;
    logic [NUM_REQ-1:0]   win_dec;

    // Scan from the farthest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_hit = 1'b0;
        win_id  = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[3'(ptr + 3'(i))]) begin
                win_hit = 1'b1;
                win_id  = 3'(ptr + 3'(i));
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_dec
        assign win_dec[k] = (win_id == 3'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 3'd0;
            hold_cnt      <= 8'd0;
            bus.gnt       <= 8'h00;
            bus.gnt_id    <= 3'd0;
            bus.gnt_valid <= 1'b0;
            bus.preempt   <= 1'b0;
        end else begin
            bus.preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && win_hit) begin
                        bus.gnt       <= win_dec;
                        bus.gnt_id    <= win_id;
                        bus.gnt_valid <= 1'b1;
                        hold_cnt      <= 8'd0;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.req[bus.gnt_id] ||
                        (MAX_HOLD != 0 && hold_cnt == HOLD_LIM)) begin
                        bus.gnt       <= 8'h00;
                        bus.gnt_valid <= 1'b0;
                        ptr           <= bus.gnt_id + 3'd1;
                        bus.preempt   <= bus.req[bus.gnt_id];
                        state         <= IDLE;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_onehot_sched.sv
// Scoreboarded bench: a behavioural model predicts each edge's outputs,
// which are queued at drive time and compared after the edge.
module tb_rr_onehot_sched;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    rr_onehot_sched_if bus ();

    rr_onehot_sched #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       pre;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // model state
    bit   m_busy;
    int   m_id, m_ptr, m_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic step();
        exp_t e;
        bit   pre = 0;
        if (!m_busy) begin
            if (bus.en && bus.req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    int c = (m_ptr + k) % 8;
                    if (!m_busy && bus.req[c]) begin
                        m_busy = 1; m_id = c; m_cnt = 0;
                    end
                end
            end
        end else if (!bus.req[m_id]) begin
            m_busy = 0; m_ptr = (m_id + 1) % 8;
        end else if (m_cnt == MH - 1) begin
            m_busy = 0; m_ptr = (m_id + 1) % 8; pre = 1;
        end else begin
            m_cnt++;
        end
        e.gnt = m_busy ? 8'(1 << m_id) : 8'h00;
        e.id  = 3'(m_id);
        e.vld = m_busy;
        e.pre = pre;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(e.gnt));
        chk("gnt_valid", 32'(bus.gnt_valid), 32'(e.vld));
        chk("preempt", 32'(bus.preempt), 32'(e.pre));
        if (e.vld) chk("gnt_id", 32'(bus.gnt_id), 32'(e.id));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
        chk({tag, "_id"}, 32'(bus.gnt_id), 32'h0);
        chk({tag, "_vld"}, 32'(bus.gnt_valid), 32'h0);
        chk({tag, "_pre"}, 32'(bus.preempt), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int ids[$];
        int npre;
        bit prev_vld;

        // reset held with full request load
        bus.en = 1'b1;
        bus.req = 8'hFF;
        model_reset();
        #1;
        chk_idle("rst0");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_idle("rst_hold");
        end
        rst_n = 1'b1;

        // first grant one edge after reset release, then timeout rotation
        step();
        chk("first_gnt", 32'(bus.gnt), 32'h01);
        ids.push_back(int'(bus.gnt_id));
        prev_vld = bus.gnt_valid;
        npre = 0;
        for (int i = 0; i < 43; i++) begin
            step();
            if (bus.preempt) npre++;
            if (bus.gnt_valid && !prev_vld) ids.push_back(int'(bus.gnt_id));
            prev_vld = bus.gnt_valid;
        end
        chk("rot_count", 32'(ids.size()), 32'd9);
        for (int j = 0; j < ids.size() && j < 9; j++)
            chk("rot_seq", 32'(ids[j]), 32'(j % 8));
        chk("rot_preempts", 32'(npre), 32'd8);
        bus.req = 8'h00;
        step();
        step();

        // single requester, then pointer continues from 4
        bus.req = 8'b0000_1000;
        step();
        chk("single_id", 32'(bus.gnt_id), 32'd3);
        bus.req = 8'h00;
        step();
        chk("single_rel", 32'(bus.gnt), 32'h0);
        bus.req = 8'hFF;
        step();
        chk("ptr_after3", 32'(bus.gnt_id), 32'd4);
        bus.req = 8'h00;
        step();

        // wrap-around: release ID 6, then 7 before 0
        bus.req = 8'h40;
        step();
        chk("wrap_g6", 32'(bus.gnt_id), 32'd6);
        bus.req = 8'h00;
        step();
        bus.req = 8'h81;
        step();
        chk("wrap_g7", 32'(bus.gnt_id), 32'd7);
        bus.req = 8'h01;
        step();
        chk("wrap_dead", 32'(bus.gnt_valid), 32'd0);
        step();
        chk("wrap_g0", 32'(bus.gnt_id), 32'd0);
        bus.req = 8'h00;
        step();

        // en gating
        bus.en = 1'b0;
        bus.req = 8'h10;
        repeat (3) step();
        chk("en_block", 32'(bus.gnt_valid), 32'd0);
        bus.en = 1'b1;
        step();
        chk("en_gnt", 32'(bus.gnt), 32'h10);
        bus.en = 1'b0;
        repeat (2) step();
        chk("en_persist", 32'(bus.gnt), 32'h10);
        bus.req = 8'h00;
        step();
        bus.req = 8'hFF;
        repeat (3) step();
        chk("en_nonew", 32'(bus.gnt_valid), 32'd0);

        // async reset mid-grant
        bus.en = 1'b1;
        bus.req = 8'h20;
        step();
        chk("ar_gnt", 32'(bus.gnt), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt0", 32'(bus.gnt), 32'h0);
        chk("ar_vld0", 32'(bus.gnt_valid), 32'h0);
        @(posedge clk); #1;
        chk_idle("ar_hold");
        rst_n = 1'b1;
        model_reset();
        step();
        chk("ar_regnt", 32'(bus.gnt_id), 32'd5);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
            bus.en = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
